graph_lut_arbiter_fp16: RTL and testbench

Round-robin arbiter and sequencer that shares one 256-entry FP16 unary-function LUT (1-cycle registered ROM, for example LOG) among `NUM_REQ` graph-engine requesters. It accepts FP16 operands through per-requester valid/ready ports and drives the LUT address from the winning operand's upper 8 bits. It tracks the requester ID across the ROM latency and returns each result on a single tagged response port. A 2-entry result FIFO with credit accounting absorbs response backpressure, because the ROM output register has no enable and its data must never be lost.

---
 rtl/graph_lut_arbiter_fp16.sv | 175 +++++++++++++++++
 tb/tb_graph_lut_arbiter_fp16.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/graph_lut_arbiter_fp16.sv
// graph_lut_arbiter_fp16: round-robin arbiter sharing one 256-entry FP16
// unary LUT (1-cycle registered ROM) among NUM_REQ requesters.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/ready/data     : per-requester FP16 operand handshake
//   lut_addr, lut_data       : LUT address out, LUT data in (1-cycle later)
//   rsp_valid/ready/id/data  : tagged response port fed by a 2-entry FIFO
//   busy                     : result in flight or FIFO non-empty
//   stat_grants/conflicts    : counters when GRAPH_LUT_ARB_STATS_EN is
//                              defined, otherwise tied to zero
module graph_lut_arbiter_fp16 #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*16-1:0] req_data,
  output logic [7:0]            lut_addr,
  input  logic [15:0]           lut_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [15:0]           rsp_data,
  output logic                  busy,
  output logic [31:0]           stat_grants,
  output logic [31:0]           stat_conflicts
);

  logic [1:0]      occ;
  logic            inflight;
  logic [ID_W-1:0] inflight_id;
  logic [ID_W-1:0] rr_ptr;

  logic [ID_W-1:0] head_id;
  logic [15:0]     head_data;
  logic [ID_W-1:0] tail_id;
  logic [15:0]     tail_data;

  logic            pop;
  logic            push;
  logic [2:0]      used;
  logic            issue_en;
  logic            found;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] idx;
  logic [ID_W-1:0] rr_next;

  assign rsp_valid = (occ != 2'd0);
  assign rsp_id    = head_id;
  assign rsp_data  = head_data;
  assign busy      = inflight | (occ != 2'd0);

  assign pop  = rsp_valid & rsp_ready;
  assign push = inflight;

  // Slots committed after this cycle; pop frees one slot now.
  assign used = {1'b0, occ}
              + {2'b00, inflight}
              - {2'b00, pop};

  // No grant while in reset: the result would be discarded.
  assign issue_en = ~rst
                  & (|req_valid)
                  & (used < 3'd2);

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign rr_next = ID_W'((int'(win) + 1) % NUM_REQ);

  always_comb begin
    req_ready = '0;
    lut_addr  = 8'h00;
    if (issue_en) begin
      req_ready[win] = 1'b1;
      lut_addr = req_data[int'(win)*16+8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      inflight    <= 1'b0;
      inflight_id <= '0;
    end else begin
      inflight <= issue_en;
      if (issue_en) begin
        rr_ptr      <= rr_next;
        inflight_id <= win;
      end
    end
  end

  // The ROM register has no enable, so every in-flight
  // result is pushed the cycle it appears.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ       <= 2'd0;
      head_id   <= '0;
      head_data <= 16'h0000;
      tail_id   <= '0;
      tail_data <= 16'h0000;
    end else begin
      unique case (1'b1)
        (push & pop): begin
          if (occ == 2'd1) begin
            head_id   <= inflight_id;
            head_data <= lut_data;
          end else begin
            head_id   <= tail_id;
            head_data <= tail_data;
            tail_id   <= inflight_id;
            tail_data <= lut_data;
          end
        end
        (push & ~pop): begin
          if (occ == 2'd0) begin
            head_id   <= inflight_id;
            head_data <= lut_data;
          end else begin
            tail_id   <= inflight_id;
            tail_data <= lut_data;
          end
          occ <= occ + 2'd1;
        end
        (~push & pop): begin
          head_id   <= tail_id;
          head_data <= tail_data;
          occ       <= occ - 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef GRAPH_LUT_ARB_STATS_EN
  logic [31:0] grants_q;
  logic [31:0] conf_q;
  logic        multi;

  assign multi = ($countones(req_valid) >= 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      grants_q <= 32'h0;
      conf_q   <= 32'h0;
    end else begin
      if (issue_en && (grants_q != 32'hFFFF_FFFF))
        grants_q <= grants_q + 32'd1;
      if (multi && (conf_q != 32'hFFFF_FFFF))
        conf_q <= conf_q + 32'd1;
    end
  end

  assign stat_grants    = grants_q;
  assign stat_conflicts = conf_q;
`else
  assign stat_grants    = 32'h0;
  assign stat_conflicts = 32'h0;
`endif

endmodule

// File: tb/tb_graph_lut_arbiter_fp16.sv
// tb_graph_lut_arbiter_fp16: directed vector table plus randomized
// traffic against a queue-based reference model of the arbiter.
module tb_graph_lut_arbiter_fp16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_data;
  logic [7:0]  lut_addr;
  logic [15:0] lut_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        busy;
  logic [31:0] stat_grants;
  logic [31:0] stat_conflicts;

  graph_lut_arbiter_fp16 #(.NUM_REQ(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data),
    .lut_addr(lut_addr), .lut_data(lut_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy),
    .stat_grants(stat_grants),
    .stat_conflicts(stat_conflicts)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_f(input logic [7:0] a);
    case (a)
      8'h3C:   return 16'h0000;
      8'h40:   return 16'h398C;
      8'h7C:   return 16'h7C00;
      default: return {a ^ 8'hA5, a};
    endcase
  endfunction

  // Registered ROM, no enable.
  always @(posedge clk) lut_data <= rom_f(lut_addr);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [63:0] data;
    logic        rdy;
    logic [3:0]  ready;
    logic [7:0]  addr;
    logic        rv;
    logic        busy;
    logic        cr;
    logic [1:0]  rid;
    logic [15:0] rdata;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic r, input logic [3:0] v,
    input logic [63:0] d, input logic y,
    input logic [3:0] er, input logic [7:0] ea,
    input logic erv, input logic eb,
    input logic cr, input logic [1:0] eid,
    input logic [15:0] ed);
    vec_t t;
    t.rst = r; t.vld = v; t.data = d; t.rdy = y;
    t.ready = er; t.addr = ea; t.rv = erv;
    t.busy = eb; t.cr = cr | erv;
    t.rid = eid; t.rdata = ed;
    return t;
  endfunction

  task automatic run_rows(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      rst       = tbl[k].rst;
      req_valid = tbl[k].vld;
      req_data  = tbl[k].data;
      rsp_ready = tbl[k].rdy;
      @(negedge clk);
      chk($sformatf("row%0d ready", k),
          32'(req_ready), 32'(tbl[k].ready));
      chk($sformatf("row%0d addr", k),
          32'(lut_addr), 32'(tbl[k].addr));
      chk($sformatf("row%0d rsp_valid", k),
          32'(rsp_valid), 32'(tbl[k].rv));
      chk($sformatf("row%0d busy", k),
          32'(busy), 32'(tbl[k].busy));
      if (tbl[k].cr) begin
        chk($sformatf("row%0d rsp_id", k),
            32'(rsp_id), 32'(tbl[k].rid));
        chk($sformatf("row%0d rsp_data", k),
            32'(rsp_data), 32'(tbl[k].rdata));
      end
      @(posedge clk); #1;
    end
  endtask

  localparam logic [63:0] F  = 64'h1300_1200_1100_1000;
  localparam logic [63:0] B  = 64'h0000_2200_2100_2000;
  localparam logic [63:0] R  = 64'h3300_0000_0000_3000;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] d;
    int          t;
  } ent_t;

  ent_t q[$];
  int   last;
  int   ngr;
  int   ncf;
  int   fair_end;

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_id", 32'(rsp_id), 32'd0);
    chk("reset rsp_data", 32'(rsp_data), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset ready", 32'(req_ready), 32'd0);
    chk("reset grants", stat_grants, 32'd0);
    chk("reset conflicts", stat_conflicts, 32'd0);
    @(posedge clk); #1;

    // single request
    tbl.push_back(mk(0,4'b0001,64'h3C00,1,4'b0001,8'h3C,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,1,1,1,0,16'h0000));
    tbl.push_back(mk(0,0,0,1,0,0,0,0,0,0,0));
    // back-to-back stream from requester 1
    tbl.push_back(mk(0,4'b0010,64'h4000_0000,1,
                     4'b0010,8'h40,0,0,0,0,0));
    tbl.push_back(mk(0,4'b0010,64'h3C00_0000,1,
                     4'b0010,8'h3C,0,1,0,0,0));
    tbl.push_back(mk(0,4'b0010,64'h7C00_0000,1,
                     4'b0010,8'h7C,1,1,1,1,16'h398C));
    tbl.push_back(mk(0,0,0,1,0,0,1,1,1,1,16'h0000));
    tbl.push_back(mk(0,0,0,1,0,0,1,1,1,1,16'h7C00));
    tbl.push_back(mk(0,0,0,1,0,0,0,0,0,0,0));
    // reset, then fairness with all four valid
    tbl.push_back(mk(1,0,0,1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,4'hF,F,1,4'b0001,8'h10,0,0,0,0,0));
    tbl.push_back(mk(0,4'hF,F,1,4'b0010,8'h11,0,1,0,0,0));
    for (int k = 2; k < 8; k++)
      tbl.push_back(mk(0,4'hF,F,1,
        4'(1 << (k % 4)), 8'(8'h10 + k % 4), 1, 1, 1,
        2'((k - 2) % 4), rom_f(8'(8'h10 + (k - 2) % 4))));
    tbl.push_back(mk(0,0,0,1,0,0,1,1,1,2,rom_f(8'h12)));
    tbl.push_back(mk(0,0,0,1,0,0,1,1,1,3,rom_f(8'h13)));
    tbl.push_back(mk(0,0,0,1,0,0,0,0,0,0,0));
    fair_end = tbl.size() - 1;
    // backpressure
    tbl.push_back(mk(0,4'b0111,B,0,4'b0001,8'h20,0,0,0,0,0));
    tbl.push_back(mk(0,4'b0110,B,0,4'b0010,8'h21,0,1,0,0,0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0,4'b0100,B,0,0,0,1,1,1,0,rom_f(8'h20)));
    tbl.push_back(mk(0,4'b0100,B,1,4'b0100,8'h22,1,1,1,0,
                     rom_f(8'h20)));
    tbl.push_back(mk(0,0,0,1,0,0,1,1,1,1,rom_f(8'h21)));
    tbl.push_back(mk(0,0,0,1,0,0,1,1,1,2,rom_f(8'h22)));
    tbl.push_back(mk(0,0,0,1,0,0,0,0,0,0,0));
    // reset with a result in flight and one queued
    tbl.push_back(mk(0,4'b1001,R,0,4'b1000,8'h33,0,0,0,0,0));
    tbl.push_back(mk(0,4'b1001,R,0,4'b0001,8'h30,0,1,0,0,0));
    tbl.push_back(mk(1,4'b1001,R,0,0,0,1,1,1,3,rom_f(8'h33)));
    tbl.push_back(mk(0,0,0,1,0,0,0,0,1,0,16'h0000));
    tbl.push_back(mk(0,0,0,1,0,0,0,0,1,0,16'h0000));
    // first post-reset grant: lowest valid index
    tbl.push_back(mk(0,4'b1001,R,1,4'b0001,8'h30,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,1,1,1,0,rom_f(8'h30)));
    tbl.push_back(mk(0,0,0,1,0,0,0,0,0,0,0));

    run_rows(0, fair_end);
`ifdef GRAPH_LUT_ARB_STATS_EN
    chk("fair grants", stat_grants, 32'd8);
    chk("fair conflicts", stat_conflicts, 32'd8);
`else
    chk("fair grants", stat_grants, 32'd0);
    chk("fair conflicts", stat_conflicts, 32'd0);
`endif
    run_rows(fair_end + 1, tbl.size() - 1);

    // randomized traffic vs reference model
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last = 3; ngr = 0; ncf = 0;
    q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic       ev, pop, iss;
      int         w;
      logic [7:0] ea;
      logic [3:0] er;
      req_valid = 4'($urandom);
      req_data  = {$urandom, $urandom};
      rsp_ready = ((cyc % 60) < 12) ? 1'b0
                : (($urandom % 4) != 0);
      @(negedge clk);
      ev = (q.size() > 0) && (cyc >= q[0].t + 2);
      chk("rnd rsp_valid", 32'(rsp_valid), 32'(ev));
      chk("rnd busy", 32'(busy), 32'(q.size() > 0));
      if (ev) begin
        chk("rnd rsp_id", 32'(rsp_id), 32'(q[0].id));
        chk("rnd rsp_data", 32'(rsp_data), 32'(q[0].d));
      end
      pop = ev && rsp_ready;
      iss = (req_valid != 0)
         && ((q.size() - int'(pop)) < 2);
      w = 0; er = '0; ea = '0;
      if (iss) begin
        for (int j = 1; j <= 4; j++)
          if (req_valid[(last + j) % 4] && er == 0) begin
            w  = (last + j) % 4;
            er = 4'(1 << w);
          end
        ea = req_data[16*w+8 +: 8];
      end
      chk("rnd ready", 32'(req_ready), 32'(er));
      chk("rnd addr", 32'(lut_addr), 32'(ea));
      if (pop) void'(q.pop_front());
      if (iss) begin
        q.push_back('{2'(w), rom_f(ea), cyc});
        last = w;
        ngr++;
      end
      if ($countones(req_valid) >= 2) ncf++;
      @(posedge clk); #1;
    end
`ifdef GRAPH_LUT_ARB_STATS_EN
    chk("rnd grants", stat_grants, 32'(ngr));
    chk("rnd conflicts", stat_conflicts, 32'(ncf));
`else
    chk("rnd grants", stat_grants, 32'd0);
    chk("rnd conflicts", stat_conflicts, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
